// File: rtl/wb_ccff_loader_if.sv
// Wishbone slave bus bundle for the configuration-chain loader.
interface wb_ccff_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_ccff_loader.sv
// Wishbone-programmed loader that streams FIFO'd bitstream words into
// NUM_CHAINS serial configuration chains with a divided programming clock.
module wb_ccff_loader #(
  parameter int unsigned NUM_CHAINS = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_ccff_loader_if.slave       wbs,
  output logic                  prog_clk_o,
  output logic [NUM_CHAINS-1:0] ccff_head_o,
  input  logic [NUM_CHAINS-1:0] ccff_tail_i,
  output logic                  prog_reset_o,
  output logic                  done_irq_o
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned BPW = 32 / NUM_CHAINS;
  localparam int unsigned BCW = 6;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOW, S_HIGH, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  prog_reset_q, prog_reset_d;
  logic [7:0]            div_q, div_d;
  logic [31:0]           length_q, length_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           tail_q, tail_d;
  logic [31:0]           fifo_q [FIFO_DEPTH];
  logic [31:0]           fifo_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [7:0]            div_cnt_q, div_cnt_d;
  logic [31:0]           pulse_cnt_q, pulse_cnt_d;
  logic [31:0]           shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  prog_clk_q, prog_clk_d;
  logic [NUM_CHAINS-1:0] head_q, head_d;

  logic        req_c, wr_c, rd_c;
  logic [1:0]  adr_c;
  logic        ctrl_wr_c, status_wr_c, data_wr_c, length_wr_c;
  logic        start_c, abort_c, push_c, pop_c;
  logic        fifo_full_c, fifo_empty_c, busy_c;
  logic [31:0] status_c, ctrl_c;
  logic        unused_c;

  // Bus decode: a request is accepted once, on the edge that raises ack.
  assign req_c        = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
  assign wr_c         = req_c & wbs.wbs_we_i;
  assign rd_c         = req_c & ~wbs.wbs_we_i;
  assign adr_c        = wbs.wbs_adr_i[3:2];
  assign ctrl_wr_c    = wr_c && (adr_c == 2'd0);
  assign status_wr_c  = wr_c && (adr_c == 2'd1);
  assign data_wr_c    = wr_c && (adr_c == 2'd2);
  assign length_wr_c  = wr_c && (adr_c == 2'd3);
  assign abort_c      = ctrl_wr_c & wbs.wbs_dat_i[1];
  assign start_c      = ctrl_wr_c & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[1];
  assign fifo_full_c  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty_c = (level_q == '0);
  assign busy_c       = (state_q == S_FETCH) || (state_q == S_LOW) || (state_q == S_HIGH);
  assign push_c       = data_wr_c & ~fifo_full_c;
  assign pop_c        = (state_q == S_FETCH) & ~fifo_empty_c & ~abort_c;
  assign status_c     = {16'h0, 8'(level_q), 3'h0, ovf_q, done_q, fifo_empty_c, fifo_full_c, busy_c};
  assign ctrl_c       = {16'h0, div_q, 5'h0, prog_reset_q, 2'b00};
  assign unused_c     = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0]};

  // Shift sequencer: next state, counters and registered chain outputs.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tail_d      = tail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_c) begin
          pulse_cnt_d = '0;
          state_d     = (length_q == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!fifo_empty_c) begin
          shift_d   = fifo_q[rd_ptr_q];
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          tail_d    = {ccff_tail_i, tail_q[31:NUM_CHAINS]};
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d   = '0;
          pulse_cnt_d = pulse_cnt_q + 32'd1;
          shift_d     = shift_q >> NUM_CHAINS;
          bit_cnt_d   = bit_cnt_q + BCW'(1);
          if (pulse_cnt_d == length_q)       state_d = S_DONE;
          else if (bit_cnt_d == BCW'(BPW))   state_d = S_FETCH;
          else                               state_d = S_LOW;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_c) begin
      state_d     = S_IDLE;
      pulse_cnt_d = '0;
      div_cnt_d   = '0;
      tail_d      = tail_q;
    end
    prog_clk_d = (state_d == S_HIGH);
    head_d     = ((state_d == S_LOW) || (state_d == S_HIGH)) ? shift_d[NUM_CHAINS-1:0] : '0;
  end

  // Register file, bus response and status flags.
  always_comb begin
    ack_d        = req_c;
    rdata_d      = '0;
    prog_reset_d = prog_reset_q;
    div_d        = div_q;
    length_d     = length_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    if (rd_c) begin
      case (adr_c)
        2'd0:    rdata_d = ctrl_c;
        2'd1:    rdata_d = status_c;
        2'd2:    rdata_d = tail_q;
        default: rdata_d = length_q;
      endcase
    end
    if (ctrl_wr_c) begin
      prog_reset_d = wbs.wbs_dat_i[2];
      div_d        = wbs.wbs_dat_i[15:8];
    end
    if (length_wr_c) length_d = wbs.wbs_dat_i;
    if (status_wr_c && wbs.wbs_dat_i[3]) done_d = 1'b0;
    if (status_wr_c && wbs.wbs_dat_i[4]) ovf_d  = 1'b0;
    if (data_wr_c && fifo_full_c) ovf_d = 1'b1;
    if (start_c && ((state_q == S_IDLE) || (state_q == S_DONE))) done_d = 1'b0;
    if (state_d == S_DONE) done_d = 1'b1;
  end

  // Bitstream FIFO; a same-cycle push and pop leave the level unchanged.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) begin
        fifo_d[wr_ptr_q] = wbs.wbs_dat_i;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_c) - LW'(pop_c);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      prog_reset_q <= 1'b0;
      div_q        <= '0;
      length_q     <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      tail_q       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      div_cnt_q    <= '0;
      pulse_cnt_q  <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      prog_clk_q   <= 1'b0;
      head_q       <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      prog_reset_q <= prog_reset_d;
      div_q        <= div_d;
      length_q     <= length_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      tail_q       <= tail_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      div_cnt_q    <= div_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      prog_clk_q   <= prog_clk_d;
      head_q       <= head_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdata_q;
  assign prog_clk_o    = prog_clk_q;
  assign ccff_head_o   = head_q;
  assign prog_reset_o  = prog_reset_q;
  assign done_irq_o    = done_q;

endmodule

// File: tb/tb_wb_ccff_loader.sv
// Directed bench for wb_ccff_loader: one single-chain and one four-chain instance.
module tb_wb_ccff_loader;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_STATUS = 2'd1;
  localparam logic [1:0] R_DATA   = 2'd2;
  localparam logic [1:0] R_LENGTH = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pclk1, preset1, irq1;
  logic [0:0] head1, tail1;
  logic       pclk4, preset4, irq4;
  logic [3:0] head4, tail4;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] hv [64];
  int         rc [64];
  int         np;
  logic       dn;

  wb_ccff_loader_if bus1();
  wb_ccff_loader_if bus4();

  assign tail1 = head1;
  assign tail4 = head4;

  wb_ccff_loader #(.NUM_CHAINS(1), .FIFO_DEPTH(4)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus1),
    .prog_clk_o(pclk1), .ccff_head_o(head1), .ccff_tail_i(tail1),
    .prog_reset_o(preset1), .done_irq_o(irq1)
  );

  wb_ccff_loader #(.NUM_CHAINS(4), .FIFO_DEPTH(4)) u_dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus4),
    .prog_clk_o(pclk4), .ccff_head_o(head4), .ccff_tail_i(tail4),
    .prog_reset_o(preset4), .done_irq_o(irq4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input int dut, input logic we, input logic [1:0] ra,
                         input logic [31:0] wd, output logic [31:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = '0;
    bus1.wbs_adr_i = {28'h0, ra, 2'b00};
    bus4.wbs_adr_i = {28'h0, ra, 2'b00};
    bus1.wbs_we_i  = we;
    bus4.wbs_we_i  = we;
    bus1.wbs_dat_i = wd;
    bus4.wbs_dat_i = wd;
    if (dut == 1) begin bus1.wbs_stb_i = 1'b1; bus1.wbs_cyc_i = 1'b1; end
    else          begin bus4.wbs_stb_i = 1'b1; bus4.wbs_cyc_i = 1'b1; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (dut == 1 && bus1.wbs_ack_o) begin got = 1'b1; rdat = bus1.wbs_dat_o; end
      if (dut == 4 && bus4.wbs_ack_o) begin got = 1'b1; rdat = bus4.wbs_dat_o; end
    end
    bus1.wbs_stb_i = 1'b0; bus1.wbs_cyc_i = 1'b0;
    bus4.wbs_stb_i = 1'b0; bus4.wbs_cyc_i = 1'b0;
    chk("wb_ack", 32'(got), 32'd1);
  endtask

  task automatic wr(input int dut, input logic [1:0] ra, input logic [31:0] wd);
    logic [31:0] d;
    wb_xfer(dut, 1'b1, ra, wd, d);
  endtask

  task automatic rd(input int dut, input logic [1:0] ra, output logic [31:0] d);
    wb_xfer(dut, 1'b0, ra, 32'h0, d);
  endtask

  // Record head value and cycle index at each prog_clk rise until done_irq.
  task automatic run_pulses(input int dut, input int budget);
    logic prev, pc, irq;
    logic [7:0] hd;
    np   = 0;
    dn   = 1'b0;
    prev = (dut == 1) ? pclk1 : pclk4;
    for (int c = 0; c < budget && !dn; c++) begin
      @(posedge clk); #1;
      pc  = (dut == 1) ? pclk1 : pclk4;
      hd  = (dut == 1) ? 8'(head1) : 8'(head4);
      irq = (dut == 1) ? irq1 : irq4;
      if (pc && !prev && np < 64) begin
        hv[np] = hd;
        rc[np] = c;
        np++;
      end
      prev = pc;
      if (irq) dn = 1'b1;
    end
  endtask

  task automatic wait_rises(input int n, input int budget, output int seen);
    logic prev;
    seen = 0;
    prev = pclk1;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(posedge clk); #1;
      if (pclk1 && !prev) seen++;
      prev = pclk1;
    end
  endtask

  initial begin
    logic [31:0] r;
    int          viol;
    int          seen;
    logic [7:0]  exp4 [10];
    exp4 = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8, 8'h9, 8'h0};

    bus1.wbs_stb_i = 1'b0; bus1.wbs_cyc_i = 1'b0; bus1.wbs_we_i = 1'b0;
    bus1.wbs_sel_i = 4'hF; bus1.wbs_dat_i = '0;   bus1.wbs_adr_i = '0;
    bus4.wbs_stb_i = 1'b0; bus4.wbs_cyc_i = 1'b0; bus4.wbs_we_i = 1'b0;
    bus4.wbs_sel_i = 4'hF; bus4.wbs_dat_i = '0;   bus4.wbs_adr_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prog_clk", 32'(pclk1), 32'd0);
    chk("rst_head", 32'(head1), 32'd0);
    chk("rst_irq", 32'(irq1), 32'd0);
    chk("rst_ack", 32'(bus1.wbs_ack_o), 32'd0);
    chk("rst_prog_reset", 32'(preset1), 32'd0);
    rst = 1'b0;
    rd(1, R_STATUS, r); chk("rst_status", r, 32'h0000_0004);
    rd(1, R_CTRL, r);   chk("rst_ctrl", r, 32'h0000_0000);

    // prog_reset is a plain control bit
    wr(1, R_CTRL, 32'h0000_0004);
    chk("prog_reset_set", 32'(preset1), 32'd1);
    wr(1, R_CTRL, 32'h0000_0000);
    chk("prog_reset_clr", 32'(preset1), 32'd0);

    // single chain, DIV=0, 0xA5 over 8 pulses
    wr(1, R_LENGTH, 32'd8);
    wr(1, R_DATA, 32'h0000_00A5);
    wr(1, R_CTRL, 32'h0000_0001);
    run_pulses(1, 200);
    chk("a5_done_seen", 32'(dn), 32'd1);
    chk("a5_pulses", 32'(np), 32'd8);
    for (int k = 0; k < 8; k++) chk("a5_head", 32'(hv[k]), 32'((8'hA5 >> k) & 8'h1));
    for (int k = 1; k < 8; k++) chk("a5_period", 32'(rc[k] - rc[k-1]), 32'd2);
    chk("a5_irq", 32'(irq1), 32'd1);
    rd(1, R_STATUS, r); chk("a5_status", r, 32'h0000_000C);
    wr(1, R_STATUS, 32'h0000_0008);
    chk("w1c_irq", 32'(irq1), 32'd0);

    // four chains, DIV=1, two words, 10 pulses
    wr(4, R_LENGTH, 32'd10);
    wr(4, R_DATA, 32'h8765_4321);
    wr(4, R_DATA, 32'hFEDC_BA09);
    wr(4, R_CTRL, 32'h0000_0101);
    run_pulses(4, 300);
    chk("x4_done_seen", 32'(dn), 32'd1);
    chk("x4_pulses", 32'(np), 32'd10);
    for (int k = 0; k < 10; k++) chk("x4_head", 32'(hv[k]), 32'(exp4[k]));
    for (int k = 1; k < 10; k++) chk("x4_period", 32'(rc[k] - rc[k-1]), (k == 8) ? 32'd5 : 32'd4);
    rd(4, R_STATUS, r); chk("x4_status", r, 32'h0000_000C);

    // start with empty FIFO stalls in FETCH
    wr(1, R_LENGTH, 32'd4);
    wr(1, R_CTRL, 32'h0000_0001);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pclk1 !== 1'b0) viol++;
    end
    chk("stall_prog_clk", 32'(viol), 32'd0);
    rd(1, R_STATUS, r); chk("stall_status", r, 32'h0000_0005);
    wr(1, R_DATA, 32'h0000_000B);
    run_pulses(1, 200);
    chk("stall_pulses", 32'(np), 32'd4);
    for (int k = 0; k < 4; k++) chk("stall_head", 32'(hv[k]), 32'((8'h0B >> k) & 8'h1));

    // overflow on FIFO_DEPTH+1 writes
    for (int i = 1; i <= 5; i++) wr(1, R_DATA, 32'(i * 32'h11));
    rd(1, R_STATUS, r); chk("ovf_status", r, 32'h0000_041A);
    wr(1, R_STATUS, 32'h0000_0018);
    rd(1, R_STATUS, r); chk("ovf_w1c", r, 32'h0000_0402);

    // abort during HIGH of pulse 3
    wr(1, R_LENGTH, 32'd8);
    wr(1, R_CTRL, 32'h0000_0301);
    wait_rises(3, 200, seen);
    chk("abort_rises", 32'(seen), 32'd3);
    wr(1, R_CTRL, 32'h0000_0302);
    chk("abort_prog_clk", 32'(pclk1), 32'd0);
    rd(1, R_STATUS, r); chk("abort_status", r, 32'h0000_0004);
    chk("abort_irq", 32'(irq1), 32'd0);

    // reset during HIGH of pulse 3
    wr(1, R_DATA, 32'h0000_00FF);
    wr(1, R_DATA, 32'h0000_00FF);
    wr(1, R_CTRL, 32'h0000_0301);
    wait_rises(3, 200, seen);
    chk("rst_mid_rises", 32'(seen), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_prog_clk", 32'(pclk1), 32'd0);
    chk("rst_mid_head", 32'(head1), 32'd0);
    chk("rst_mid_irq", 32'(irq1), 32'd0);
    rd(1, R_STATUS, r); chk("rst_mid_status", r, 32'h0000_0004);
    rd(1, R_CTRL, r);   chk("rst_mid_ctrl", r, 32'h0000_0000);
    rd(1, R_LENGTH, r); chk("rst_mid_length", r, 32'h0000_0000);

    // loopback head->tail over a full word
    wr(1, R_LENGTH, 32'd32);
    wr(1, R_DATA, 32'h1234_5678);
    wr(1, R_CTRL, 32'h0000_0001);
    run_pulses(1, 300);
    chk("loop_pulses", 32'(np), 32'd32);
    rd(1, R_DATA, r); chk("loop_tail", r, 32'h1234_5678);
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(bus1.wbs_ack_o), 32'd0);
    chk("dat_idle_zero", bus1.wbs_dat_o, 32'h0);

    // LENGTH=0 goes straight to done
    wr(1, R_STATUS, 32'h0000_0008);
    wr(1, R_LENGTH, 32'd0);
    wr(1, R_CTRL, 32'h0000_0001);
    chk("len0_irq", 32'(irq1), 32'd1);
    chk("len0_prog_clk", 32'(pclk1), 32'd0);
    rd(1, R_STATUS, r); chk("len0_status", r, 32'h0000_000C);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
